fixp_dot_acc: RTL and testbench
===============================

// Module: fixp_dot_acc
// PURPOSE
// Streaming fixed-point dot-product engine: multiplies (a,b) pairs with fixpmul arithmetic and accumulates them.
// Sits downstream of the fixed-point multiply stage; feeds energy/log-likelihood sums to the MCMC acceptance logic.
// Accepts one pair per cycle with valid/ready, ends a vector on in_last and returns one saturated Q(IW.FW) sum per vector.
// PARAMETERS
// IW    8  integer bits incl. sign (W = IW+FW total operand/result width)
// FW    8  fractional bits
// GB    4  accumulator guard bits above the full product range
// PORTS
// clk        in   1    clock, rising edge
// rst        in   1    reset, asynchronous, active-high
// in_valid   in   1    input pair valid
// in_ready   out  1    block can accept a pair this cycle
// in_a       in   W    signed Q(IW.FW) operand a
// in_b       in   W    signed Q(IW.FW) operand b
// in_last    in   1    this pair is the final element of the vector
// out_valid  out  1    out_sum holds a completed vector result
// out_ready  in   1    consumer takes out_sum this cycle
// out_sum    out  W    signed Q(IW.FW) saturated dot product
// out_sat    out  1    out_sum was clipped (qualified by out_valid)
// BEHAVIOUR
// Widths: raw product P = in_a*in_b, signed 2W bits; scaled term T = P >>> FW (arithmetic shift, floor rounding, 2W-FW bits).
// Accumulator ACC: signed 2W-FW+GB bits; T sign-extended into it; no wrap within 2^GB terms of full-scale magnitude.
// Pipeline: S1 registers T, last flag and v1; S2 is ACC plus the output register. Stalls are global.
// adv = !(out_valid && !out_ready); in_ready = adv (combinational). Accept = in_valid && in_ready.
// S1 loads on adv: v1 <= Accept, T1/l1 <= product/in_last of the accepted pair; v1 clears if no accept.
// S2 on adv && v1 && !l1: ACC <= ACC + T1.
// S2 on adv && v1 && l1: S = ACC + T1; out_sum <= sat_W(S); out_sat <= (S > 2^(W-1)-1) || (S < -2^(W-1)); out_valid <= 1; ACC <= 0.
// Saturation limits: 0x7FFF / 0x8000 for W=16.
// out_valid clears on out_valid && out_ready unless a new result is loaded in the same cycle (new result wins, stays 1).
// When adv=0 all of S1, S2 and ACC hold. out_sum/out_sat stay stable while out_valid && !out_ready.
// Latency: last pair accepted in cycle N -> out_valid=1 in cycle N+2. Throughput is 1 pair/cycle with out_ready=1.
// A single pair with in_last=1 is a valid 1-element vector. Back-to-back vectors need no bubble.
// Accumulation of the next vector starts from ACC=0 in the cycle after the last term.
// Reset (async, any time incl. mid-vector): v1=0, T1=0, l1=0, ACC=0, out_valid=0, out_sum=0, out_sat=0.
// Partial vectors in flight are discarded. in_ready=1 while rst is deasserted and out_valid=0.
// in_a, in_b and in_last are ignored when Accept=0. No X on outputs after reset.
// TESTING
// 1) (0x0100,0x0100),(0x0200,0x0080 last) -> out_sum=0x0200, out_sat=0, out_valid at accept_last+2.
// 2) Floor rounding: (0x0001,0x0001 last) -> 0x0000; (0xFFFF,0x0001 last) -> 0xFFFF.
// 3) Negative: (0xFE80,0x0200 last) [-1.5*2] -> 0xFD00; then (0x4000,0x0400 last) -> 0x7FFF, out_sat=1.
// 4) Negative saturation: 4x (0x8000,0x7FFF), last on the 4th -> 0x8000, out_sat=1; next vector (0x0100,0x0100 last) -> 0x0100, sat=0.
// 5) Backpressure: out_ready=0 for 5 cycles while 3 vectors stream -> in_ready drops, no lost/duplicated result, sums in order.
// 6) Assert rst mid-vector after 2 pairs -> out_valid=0 immediately; next vector (0x0300,0x0100 last) -> 0x0300 (no stale ACC).

Source files
------------

// File: rtl/fixp_dot_acc.sv
// Streaming fixed-point dot-product engine: floor-scaled Q(IW.FW) products summed
// over each in_last-terminated vector, one saturated result per vector.
module fixp_dot_acc #(
  parameter int IW = 8,
  parameter int FW = 8,
  parameter int GB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IW+FW-1:0]   in_a,
  input  logic [IW+FW-1:0]   in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW+FW-1:0]   out_sum,
  output logic               out_sat
);
  localparam int W  = IW + FW;
  localparam int TW = 2*W - FW;
  localparam int AW = TW + GB;

  logic          v1_q, v1_d;
  logic          l1_q, l1_d;
  logic [TW-1:0] t1_q, t1_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_sum_q, out_sum_d;
  logic          out_sat_q, out_sat_d;

  logic          adv;
  logic          accept;
  logic [2*W-1:0] a_ext, b_ext, prod;
  logic [AW-1:0] sum;
  logic          ovf;

  always_comb begin
    adv    = !(out_valid_q && !out_ready);
    accept = in_valid && adv;

    a_ext = {{W{in_a[W-1]}}, in_a};
    b_ext = {{W{in_b[W-1]}}, in_b};
    prod  = a_ext * b_ext;

    sum = acc_q + {{GB{t1_q[TW-1]}}, t1_q};
    // The sum fits W bits exactly when every bit from the W-1 sign position up agrees.
    ovf = !((&sum[AW-1:W-1]) || !(|sum[AW-1:W-1]));

    v1_d        = v1_q;
    l1_d        = l1_q;
    t1_d        = t1_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    if (adv) begin
      v1_d = accept;
      if (accept) begin
        t1_d = prod[2*W-1:FW];
        l1_d = in_last;
      end
      if (v1_q) begin
        if (l1_q) begin
          out_sum_d   = ovf ? (sum[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                            : sum[W-1:0];
          out_sat_d   = ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      t1_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      t1_q        <= t1_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fixp_dot_acc.sv
// Directed bench for fixp_dot_acc: hand-computed Q8.8 dot products, saturation,
// backpressure ordering and asynchronous reset mid-vector.
module tb_fixp_dot_acc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  fixp_dot_acc #(.IW(8), .FW(8), .GB(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] es, input logic es_sat);
    int unsigned n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(out_sum),   32'(es));
    chk({tag, "_sat"},   32'(out_sat),   32'(es_sat));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vl [4];
    logic [15:0] got [$];
    logic [15:0] held;
    bit          holding;
    bit          saw_stall;
    int          idx;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 1) 1*1 + 2*0.5 = 2.0, with latency check
    send(16'h0100, 16'h0100, 1'b0);
    send(16'h0200, 16'h0080, 1'b1);
    chk("t1_lat_n1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_n2", 32'(out_valid), 32'd1);
    chk("t1_sum",    32'(out_sum),   32'h0200);
    chk("t1_sat",    32'(out_sat),   32'd0);
    @(posedge clk); #1;
    chk("t1_clear",  32'(out_valid), 32'd0);

    // 2) floor rounding
    send(16'h0001, 16'h0001, 1'b1);
    expect_result("t2_pos", 16'h0000, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1);
    expect_result("t2_neg", 16'hFFFF, 1'b0);

    // 3) negative result, then positive saturation
    send(16'hFE80, 16'h0200, 1'b1);
    expect_result("t3_neg", 16'hFD00, 1'b0);
    send(16'h4000, 16'h0400, 1'b1);
    expect_result("t3_psat", 16'h7FFF, 1'b1);

    // 4) negative saturation, then clean vector from ACC=0
    send(16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h7FFF, 1'b1);
    expect_result("t4_nsat", 16'h8000, 1'b1);
    send(16'h0100, 16'h0100, 1'b1);
    expect_result("t4_next", 16'h0100, 1'b0);

    // 5) backpressure: three vectors streaming, out_ready low for 5 cycles
    va = '{16'h0100, 16'h0100, 16'h0100, 16'h0080};
    vb = '{16'h0300, 16'h0100, 16'h0100, 16'h0200};
    vl = '{1'b1, 1'b0, 1'b1, 1'b1};
    idx = 0; holding = 0; saw_stall = 0; held = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_a = va[idx]; in_b = vb[idx]; in_last = vl[idx];
      end
      #1;
      if (!in_ready) saw_stall = 1;
      if (out_valid && !out_ready) begin
        if (holding) chk("t5_hold", 32'(out_sum), 32'(held));
        held = out_sum;
        holding = 1;
      end else begin
        holding = 0;
      end
      if (out_valid && out_ready) got.push_back(out_sum);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx == 4 && got.size() == 3) break;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    chk("t5_stall", 32'(saw_stall), 32'd1);
    chk("t5_count", 32'(got.size()), 32'd3);
    chk("t5_r0", (got.size() > 0) ? 32'(got[0]) : 32'hDEAD, 32'h0300);
    chk("t5_r1", (got.size() > 1) ? 32'(got[1]) : 32'hDEAD, 32'h0200);
    chk("t5_r2", (got.size() > 2) ? 32'(got[2]) : 32'hDEAD, 32'h0100);
    @(posedge clk); #1;
    chk("t5_idle", 32'(out_valid), 32'd0);

    // 6) async reset with a pending result, then mid-vector
    out_ready = 1'b0;
    send(16'h0500, 16'h0100, 1'b1);
    @(posedge clk); #1;
    chk("t6_pend", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_sum",   32'(out_sum),   32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(16'h0100, 16'h0100, 1'b0);
    send(16'h0200, 16'h0200, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'h0300, 16'h0100, 1'b1);
    expect_result("t6_fresh", 16'h0300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
